// File: rtl/input_sig_arbiter.sv
// Round-robin arbiter sharing one input_sig capture channel among N requesters, with a hold limit.
// Optional define INPUT_SIG_ARBITER_TIMEOUT_CNT_EN adds a saturating timeout_cnt output.
module input_sig_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           timeout
`ifdef INPUT_SIG_ARBITER_TIMEOUT_CNT_EN
    ,
    output logic [7:0]     timeout_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     hcnt_q, hcnt_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q, valid_d;
    logic           timeout_q, timeout_d;
    logic [IDW-1:0] cand, pick;
    logic           found;
    logic           own_done, own_req, expired;

    // Cyclic search for the first requester starting at ptr.
    always_comb begin
        cand  = ptr_q;
        pick  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = (cand == IDW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign own_done = done[id_q];
    assign own_req  = req[id_q];
    assign expired  = (hcnt_q == 8'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        hcnt_d    = hcnt_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = N'(1) << pick;
                    id_d    = pick;
                    hcnt_d  = 8'd1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (own_done || !own_req || expired) begin
                    // Only an expiry that is not pre-empted by done or abandon pulses timeout.
                    timeout_d = !own_done && own_req;
                    grant_d   = '0;
                    hcnt_d    = 8'd0;
                    ptr_d     = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
                    state_d   = StIdle;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            id_q      <= '0;
            hcnt_q    <= 8'd0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            hcnt_q    <= hcnt_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign timeout     = timeout_q;

`ifdef INPUT_SIG_ARBITER_TIMEOUT_CNT_EN
    logic [7:0] tcnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt_q <= 8'd0;
        end else if (timeout_d && tcnt_q != 8'hFF) begin
            tcnt_q <= tcnt_q + 8'd1;
        end
    end

    assign timeout_cnt = tcnt_q;
`endif

endmodule

// File: doc/input_sig_arbiter.md
Name: input_sig_arbiter

Overview:
- Round-robin arbiter that shares one input_sig capture channel among N requesters.
- Grants the channel to one requester at a time and enforces a maximum hold time.
- Rotates priority after every release so no requester starves.
- Sits between the requesting blocks and the input_sig instance; grant_id drives that instance's input mux select.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted (1..255).
- IDW, $clog2(N), width of grant_id (derived; do not override).

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst  input  1  synchronous active-low reset; sampled on posedge clk; 0 = reset.
- req  input  N  request per requester; level, held while the requester wants the channel.
- done  input  N  release strobe per requester; only the bit of the current grantee is honoured.
- grant  output  N  one-hot grant, registered; all zero when nobody owns the channel.
- grant_valid  output  1  OR of grant, registered.
- grant_id  output  IDW  index of the current grantee; holds its last value when grant_valid=0.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (rst=0 at posedge):
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - Priority pointer ptr=0, hold counter hcnt=0, state=IDLE.
  - Reset overrides everything, including an active grant, which drops at that edge.
- State IDLE:
  - At each posedge, if req≠0, select the first set req bit searching ptr, ptr+1, … cyclically mod N.
  - Register grant (one-hot), grant_id, grant_valid=1, hcnt=1, and go to GRANT.
  - Latency: req driven high in cycle c gives grant high in cycle c+1.
  - If req=0, stay in IDLE with outputs at 0 (grant_id unchanged).
- State GRANT (owner g=grant_id). Releases are evaluated at each posedge in priority order:
  1. done[g]=1 → normal release.
  2. req[g]=0 → abandon release.
  3. hcnt==MAX_HOLD → timeout release: timeout=1 for exactly the next cycle.
  4. Otherwise hold the grant and increment hcnt.
- On any release: grant=0, grant_valid=0, hcnt=0, ptr=(g+1) mod N, go to IDLE.
- Grant width: a grant is high for at most MAX_HOLD cycles. There is always at least one idle cycle between consecutive grants, including back-to-back grants to the same or a different requester.
- done and MAX_HOLD expiry in the same cycle: done wins and no timeout pulse is generated.
- done bits of non-owners are ignored in every state. done in IDLE is ignored.
- A requester that lost its grant by timeout and keeps req high is treated like any other requester after the ptr rotation.
- req bits changing while a grant is active do not affect the owner; they only matter at the next IDLE arbitration.
- MAX_HOLD=1: every grant lasts exactly one cycle. timeout pulses unless done[g] or !req[g] was seen on that edge.
- hcnt is an 8-bit counter and never exceeds MAX_HOLD.

Optional Feature:
- Macro: INPUT_SIG_ARBITER_TIMEOUT_CNT_EN.
- When defined:
  - Adds output port timeout_cnt [7:0]: a saturating count of timeout releases since reset.
  - Reset value 0. Increments in the same edge timeout is registered. Sticks at 255.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=0 for 3 cycles with req=4'b1111 → grant=0, grant_valid=0, timeout=0. Release rst=1 with req=4'b0000 → outputs stay 0.
- Single request: req=4'b0100 driven in cycle 0 → grant=4'b0100, grant_id=2 from cycle 1. done[2] pulsed in cycle 3 → grant=0 from cycle 4. Next req[0] request wins over req[3] only after ptr passes 3.
- Round-robin: req=4'b1111 held, each owner pulses done on its 2nd grant cycle → grant sequence 0,1,2,3,0 with one idle cycle between each.
- Timeout (MAX_HOLD=8): req=4'b0001 held, no done → grant high exactly 8 cycles, timeout=1 for 1 cycle, then 1 idle cycle, then regrant to 0. With the macro on, timeout_cnt=1, then 2 after the next timeout.
- Simultaneous done and expiry: done[1]=1 in the 8th grant cycle of requester 1 → release with timeout=0. Foreign done[3]=1 during grant to 1 → no effect.
- Reset mid-grant: rst=0 in the 3rd cycle of a grant to 2 → grant=0 and ptr=0 at that edge. After rst=1 with req=4'b0110, the next grant goes to 1.
